io_bus_initiator: RTL and testbench
===================================

Name: io_bus_initiator

Overview:
- Block-transfer engine that masters the CPU-side general-purpose IO bus: IO_RD, IO_WR, IO_A, IO_BE, IO_DI, IO_Q, IO_READY.
- Acts as the initiator towards the existing RAM/ROM/tube responders, in place of the M32632 core. Intended for host-driven loads and dumps while the CPU is held.
- Accepts a command (address, byte length, direction) and moves a byte stream to or from the bus.
- Packs bytes into 32-bit accesses with byte enables, including unaligned start and end.

Parameters:
- LEN_W, 16: width of the byte-length field; max transfer is 2^LEN_W-1 bytes.
- TIMEOUT, 255: cycles to wait for IO_READY before aborting; 0 disables the timeout.

Ports:
- clk in 1: single clock. All logic is clocked on the posedge.
- rst in 1: synchronous, active-high reset.
- cmd_valid in 1: command request.
- cmd_ready out 1: high only in IDLE.
- cmd_write in 1: 1 = stream to bus, 0 = bus to stream.
- cmd_addr in 24: byte start address.
- cmd_len in LEN_W: byte count.
- wr_data in 8: write-stream byte.
- wr_valid in 1: write-stream byte valid.
- wr_ready out 1: write-stream accept.
- rd_data out 8: read-stream byte.
- rd_valid out 1: read-stream byte valid.
- rd_ready in 1: read-stream accept.
- IO_RD out 1: bus read strobe.
- IO_WR out 1: bus write strobe.
- IO_A out 32: bus address. Bits [31:24]=0, [1:0]=0.
- IO_BE out 4: byte enables; lane n = bits [8n+7:8n].
- IO_DI out 32: write data.
- IO_Q in 32: read data.
- IO_READY in 1: responder completion.
- busy out 1: high whenever not IDLE.
- done out 1: one-cycle pulse at end of a command.
- err out 1: sticky timeout flag; cleared on next command accept.

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. State IDLE; internal pointer and count cleared.
- Command handshake: a command is accepted on a cycle where cmd_valid & cmd_ready. The block latches addr and len and clears err.
  - len=0: done pulses the next cycle; no bus cycle; return to IDLE.
- States: IDLE, FILL, WBUS, RBUS, DRAIN, GAP.
- Current word: addr[23:2]. Lane window: from addr[1:0] up to lane 3, or up to the last byte of the transfer, whichever comes first.
- FILL (write):
  - wr_ready=1.
  - Each accepted byte is placed in IO_DI lane addr[1:0] and sets that BE bit. addr increments and count decrements.
  - Go to WBUS when lane 3 is filled or count reaches 0.
  - No bus strobe while collecting.
- WBUS:
  - IO_WR=1; IO_A, IO_BE, IO_DI held stable.
  - Completes on the first cycle IO_READY=1 is sampled.
  - Partial BE is legal; the responder performs the RMW.
- RBUS (read):
  - IO_RD=1 with BE covering the lane window.
  - On IO_READY=1, capture IO_Q into a 32-bit buffer, then go to DRAIN.
- DRAIN:
  - Present enabled lanes in ascending order on rd_data with rd_valid=1.
  - Advance only on rd_valid & rd_ready. addr increments and count decrements per byte.
  - After the last lane of the window, go to GAP.
- GAP:
  - Exactly one cycle with IO_RD=IO_WR=0, so the responder sees its ready deassert.
  - Then: FILL/RBUS if count≠0, else IO_BE=0, done pulse, IDLE.
- Strobe rule: IO_RD and IO_WR are never high together and are never high in any state except WBUS/RBUS.
- Timeout:
  - A counter resets on entry to WBUS/RBUS and increments each cycle IO_READY=0.
  - At TIMEOUT: drop the strobe, set err=1, pulse done, go to IDLE.
  - Remaining stream bytes are not consumed or produced.
- Address wrap: 0xFFFFFF+1 wraps to 0x000000 within 24 bits.
- IO_READY while idle (combinational responder for other addresses): ignored outside WBUS/RBUS.
- Stalls: wr_valid=0 in FILL or rd_ready=0 in DRAIN stalls indefinitely; no timeout applies.
- Reset mid-transfer: at the next edge, strobes drop and all outputs return to reset values. No done pulse.

Test Plan:
- Aligned write: addr=0x000100, len=4, bytes 11 22 33 44 → exactly one IO_WR with IO_A=0x100, BE=1111, IO_DI=0x44332211; then 1 GAP cycle; done pulse.
- Unaligned write: addr=0x000103, len=3, bytes AA BB CC, responder ready after 3 cycles:
  - Write 1: IO_A=0x100, BE=1000, DI[31:24]=AA.
  - Write 2: IO_A=0x104, BE=0011, DI[15:0]=0xCCBB.
- Read with backpressure: addr=0x000002, len=4, IO_Q=0x44332211 then 0x88776655, rd_ready toggling → reads at 0x0 (BE=1100) and 0x4 (BE=0011); stream 33 44 55 66.
- Timeout: TIMEOUT=8, IO_READY stuck 0 → IO_WR high exactly 8 cycles then 0; err=1, done pulse, cmd_ready=1. Next command clears err.
- Wrap and zero length: addr=0xFFFFFE, len=4 read → IO_A 0xFFFFFC (BE=1100) then 0x000000 (BE=0011). Separately, len=0 → no strobe, done the cycle after accept.
- Reset mid-RBUS: assert rst while IO_RD=1 → next cycle IO_RD=0, busy=0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/io_bus_initiator.sv
// io_bus_initiator: block-transfer engine that masters the CPU-side IO bus,
// packing a byte stream into 32-bit accesses with byte enables.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// FILL  | collecting write-stream bytes into the current word
// WBUS  | IO_WR asserted, waiting for IO_READY
// RBUS  | IO_RD asserted, waiting for IO_READY
// DRAIN | presenting captured read bytes on the read stream
// GAP   | one idle bus cycle between accesses
module io_bus_initiator #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [23:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             IO_RD,
    output logic             IO_WR,
    output logic [31:0]      IO_A,
    output logic [3:0]       IO_BE,
    output logic [31:0]      IO_DI,
    input  logic [31:0]      IO_Q,
    input  logic             IO_READY,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, FILL, WBUS, RBUS, DRAIN, GAP} state_t;

    // Down-counter loaded with TIMEOUT-1 on bus entry; expiry when it sits at zero with no ready.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

    state_t            state;
    logic [23:0]       addr;
    logic [LEN_W-1:0]  count;
    logic              dir_wr;
    logic [31:0]       rbuf;
    logic [TMR_W-1:0]  tmr;
    logic [1:0]        lane;
    logic [1:0]        lane_nxt;
    logic              last_byte;
    logic              tmo_hit;

    assign lane      = addr[1:0];
    assign lane_nxt  = lane + 2'd1;
    assign last_byte = (lane == 2'd3) || (count == LEN_W'(1));
    assign tmo_hit   = (TIMEOUT != 0) && (tmr == '0) && !IO_READY;

    // Lanes from lo upward, limited to the bytes still owed by the transfer.
    function automatic logic [3:0] win_mask(input logic [1:0] lo, input logic [LEN_W-1:0] cnt);
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[k] = (k >= int'(lo)) && (LEN_W'(k - int'(lo)) < cnt);
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            count     <= '0;
            dir_wr    <= 1'b0;
            rbuf      <= '0;
            tmr       <= '0;
            cmd_ready <= 1'b1;
            wr_ready  <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            IO_RD     <= 1'b0;
            IO_WR     <= 1'b0;
            IO_A      <= '0;
            IO_BE     <= '0;
            IO_DI     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr   <= cmd_addr;
                        count  <= cmd_len;
                        dir_wr <= cmd_write;
                        err    <= 1'b0;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            IO_A      <= {8'h00, cmd_addr[23:2], 2'b00};
                            if (cmd_write) begin
                                state    <= FILL;
                                wr_ready <= 1'b1;
                                IO_DI    <= '0;
                                IO_BE    <= '0;
                            end else begin
                                state <= RBUS;
                                IO_RD <= 1'b1;
                                IO_BE <= win_mask(cmd_addr[1:0], cmd_len);
                                tmr   <= TMR_LOAD;
                            end
                        end
                    end
                end

                FILL: begin
                    if (wr_valid) begin
                        IO_DI[{lane, 3'b000} +: 8] <= wr_data;
                        IO_BE[lane]                <= 1'b1;
                        addr  <= addr + 24'd1;
                        count <= count - LEN_W'(1);
                        if (last_byte) begin
                            state    <= WBUS;
                            wr_ready <= 1'b0;
                            IO_WR    <= 1'b1;
                            tmr      <= TMR_LOAD;
                        end
                    end
                end

                WBUS: begin
                    if (IO_READY) begin
                        IO_WR <= 1'b0;
                        state <= GAP;
                    end else if (tmo_hit) begin
                        IO_WR     <= 1'b0;
                        IO_BE     <= '0;
                        err       <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end

                RBUS: begin
                    if (IO_READY) begin
                        IO_RD    <= 1'b0;
                        rbuf     <= IO_Q;
                        rd_data  <= IO_Q[{lane, 3'b000} +: 8];
                        rd_valid <= 1'b1;
                        state    <= DRAIN;
                    end else if (tmo_hit) begin
                        IO_RD     <= 1'b0;
                        IO_BE     <= '0;
                        err       <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end

                DRAIN: begin
                    if (rd_ready) begin
                        addr  <= addr + 24'd1;
                        count <= count - LEN_W'(1);
                        if (last_byte) begin
                            rd_valid <= 1'b0;
                            state    <= GAP;
                        end else begin
                            rd_data <= rbuf[{lane_nxt, 3'b000} +: 8];
                        end
                    end
                end

                GAP: begin
                    if (count != '0) begin
                        IO_A <= {8'h00, addr[23:2], 2'b00};
                        if (dir_wr) begin
                            state    <= FILL;
                            wr_ready <= 1'b1;
                            IO_DI    <= '0;
                            IO_BE    <= '0;
                        end else begin
                            state <= RBUS;
                            IO_RD <= 1'b1;
                            IO_BE <= win_mask(addr[1:0], count);
                            tmr   <= TMR_LOAD;
                        end
                    end else begin
                        IO_BE     <= '0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_initiator.sv
// Self-checking bench for io_bus_initiator: scoreboarded bus accesses and
// read-stream bytes against a simple memory/latency responder model.
module tb_io_bus_initiator;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_write = 1'b0;
    logic [23:0]      cmd_addr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [7:0]       wr_data = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic             IO_RD, IO_WR;
    logic [31:0]      IO_A, IO_DI, IO_Q;
    logic [3:0]       IO_BE;
    logic             IO_READY;
    logic             busy, done, err;

    io_bus_initiator #(.LEN_W(LEN_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .IO_RD(IO_RD), .IO_WR(IO_WR), .IO_A(IO_A), .IO_BE(IO_BE),
        .IO_DI(IO_DI), .IO_Q(IO_Q), .IO_READY(IO_READY),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] di;
    } bus_t;

    bus_t       exp_bus[$];
    bus_t       obs_bus[$];
    logic [7:0] exp_rd[$];
    logic [7:0] obs_rd[$];
    logic [31:0] mem [16];
    logic [7:0]  src [8];

    int vectors = 0;
    int miscompares = 0;

    // Responder: ready after `lat` strobe cycles unless stuck; idle_ready forces ready outside transfers.
    int   lat = 0;
    logic stuck = 1'b0;
    logic idle_ready = 1'b0;
    int   wcnt = 0;

    assign IO_Q     = mem[IO_A[5:2]];
    assign IO_READY = idle_ready | ((IO_RD | IO_WR) & ~stuck & (wcnt >= lat));

    always @(posedge clk) wcnt <= (IO_RD || IO_WR) ? wcnt + 1 : 0;

    int cyc = 0, hs_cyc = 0, done_cyc = 0, done_cnt = 0;
    int wr_hi = 0, strobe_cnt = 0, overlap = 0;

    always @(negedge clk) begin
        cyc++;
        if (IO_RD && IO_WR) overlap++;
        if (IO_WR) wr_hi++;
        if (IO_RD || IO_WR) strobe_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if ((IO_RD || IO_WR) && IO_READY) begin
            obs_bus.push_back(bus_t'{IO_WR, IO_A, IO_BE, IO_DI});
            hs_cyc = cyc;
        end
        if (rd_valid && rd_ready) obs_rd.push_back(rd_data);
    end

    function automatic logic [31:0] lanes(input logic wr, input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{wr & be[k]}};
        return m;
    endfunction

    task automatic start_cmd(input logic w, input logic [23:0] a, input logic [LEN_W-1:0] l);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input int n, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            wr_data = src[i]; wr_valid = 1'b1;
            for (int g = 0; g < 100; g++) begin
                @(negedge clk);
                if (wr_ready) break;
            end
            if (!wr_ready) ok = 1'b0;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, input bit toggle, output bit ok, output int cycles);
        ok = 1'b0; cycles = 0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1; cycles = c;
                break;
            end
            @(posedge clk); #1;
            rd_ready = toggle ? ~rd_ready : 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({cmd_ready, wr_ready, rd_valid, IO_RD, IO_WR, busy, done, err} !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 10000000",
                     {cmd_ready, wr_ready, rd_valid, IO_RD, IO_WR, busy, done, err});
        end
        vectors++;
        if ({IO_A, IO_BE, IO_DI, rd_data} !== 76'd0) begin
            miscompares++;
            $display("FAIL reset_data: got a=%h be=%b di=%h rd=%h expected all zero", IO_A, IO_BE, IO_DI, rd_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_aligned();
        bit ok1, ok2; int n; bus_t e, o;
        lat = 0;
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
        exp_bus.push_back(bus_t'{1'b1, 32'h0000_0100, 4'b1111, 32'h4433_2211});
        start_cmd(1'b1, 24'h000100, 16'd4);
        feed(4, ok1);
        wait_done(100, 1'b0, ok2, n);
        vectors++;
        if ({ok1, ok2} !== 2'b11) begin
            miscompares++; $display("FAIL wr_aligned_done: got feed/done %b expected 11", {ok1, ok2});
        end
        vectors++;
        if (done_cyc - hs_cyc !== 2) begin
            miscompares++; $display("FAIL wr_aligned_gap: got %0d cycles ready->done expected 2", done_cyc - hs_cyc);
        end
        vectors++;
        if ({busy, cmd_ready, IO_BE} !== 6'b01_0000) begin
            miscompares++; $display("FAIL wr_aligned_idle: got busy/cmd_ready/be %b expected 010000", {busy, cmd_ready, IO_BE});
        end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); vectors++;
            if (obs_bus.size() == 0) begin
                miscompares++; $display("FAIL wr_aligned_bus: got no access expected a=%h be=%b", e.a, e.be);
            end else begin
                o = obs_bus.pop_front();
                if ({o.wr, o.a, o.be, o.di & lanes(o.wr, o.be)} !== {e.wr, e.a, e.be, e.di & lanes(e.wr, e.be)}) begin
                    miscompares++;
                    $display("FAIL wr_aligned_bus: got wr=%b a=%h be=%b di=%h expected wr=%b a=%h be=%b di=%h",
                             o.wr, o.a, o.be, o.di, e.wr, e.a, e.be, e.di);
                end
            end
        end
        vectors++;
        if (obs_bus.size() != 0) begin
            miscompares++; $display("FAIL wr_aligned_extra: got %0d extra accesses expected 0", obs_bus.size());
            obs_bus.delete();
        end
    endtask

    task automatic test_write_unaligned();
        bit ok1, ok2; int n; bus_t e, o;
        lat = 3;
        src[0] = 8'hAA; src[1] = 8'hBB; src[2] = 8'hCC;
        exp_bus.push_back(bus_t'{1'b1, 32'h0000_0100, 4'b1000, 32'hAA00_0000});
        exp_bus.push_back(bus_t'{1'b1, 32'h0000_0104, 4'b0011, 32'h0000_CCBB});
        start_cmd(1'b1, 24'h000103, 16'd3);
        feed(3, ok1);
        wait_done(100, 1'b0, ok2, n);
        vectors++;
        if ({ok1, ok2} !== 2'b11) begin
            miscompares++; $display("FAIL wr_unaligned_done: got feed/done %b expected 11", {ok1, ok2});
        end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); vectors++;
            if (obs_bus.size() == 0) begin
                miscompares++; $display("FAIL wr_unaligned_bus: got no access expected a=%h be=%b", e.a, e.be);
            end else begin
                o = obs_bus.pop_front();
                if ({o.wr, o.a, o.be, o.di & lanes(o.wr, o.be)} !== {e.wr, e.a, e.be, e.di & lanes(e.wr, e.be)}) begin
                    miscompares++;
                    $display("FAIL wr_unaligned_bus: got wr=%b a=%h be=%b di=%h expected wr=%b a=%h be=%b di=%h",
                             o.wr, o.a, o.be, o.di, e.wr, e.a, e.be, e.di);
                end
            end
        end
        vectors++;
        if (obs_bus.size() != 0) begin
            miscompares++; $display("FAIL wr_unaligned_extra: got %0d extra accesses expected 0", obs_bus.size());
            obs_bus.delete();
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2; int n, snap; bus_t e, o;
        lat = 1;
        for (int i = 0; i < 6; i++) src[i] = 8'(i + 1);
        exp_bus.push_back(bus_t'{1'b1, 32'h0000_0020, 4'b1110, 32'h0302_0100});
        exp_bus.push_back(bus_t'{1'b1, 32'h0000_0024, 4'b0111, 32'h0006_0504});
        snap = wr_hi;
        start_cmd(1'b1, 24'h000021, 16'd6);
        feed(6, ok1);
        wait_done(100, 1'b0, ok2, n);
        vectors++;
        if ({ok1, ok2} !== 2'b11) begin
            miscompares++; $display("FAIL b2b_done: got feed/done %b expected 11", {ok1, ok2});
        end
        vectors++;
        if (wr_hi - snap !== 4) begin
            miscompares++; $display("FAIL b2b_wr_cycles: got %0d expected 4", wr_hi - snap);
        end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); vectors++;
            if (obs_bus.size() == 0) begin
                miscompares++; $display("FAIL b2b_bus: got no access expected a=%h be=%b", e.a, e.be);
            end else begin
                o = obs_bus.pop_front();
                if ({o.wr, o.a, o.be, o.di & lanes(o.wr, o.be)} !== {e.wr, e.a, e.be, e.di & lanes(e.wr, e.be)}) begin
                    miscompares++;
                    $display("FAIL b2b_bus: got wr=%b a=%h be=%b di=%h expected wr=%b a=%h be=%b di=%h",
                             o.wr, o.a, o.be, o.di, e.wr, e.a, e.be, e.di);
                end
            end
        end
        vectors++;
        if (obs_bus.size() != 0) begin
            miscompares++; $display("FAIL b2b_extra: got %0d extra accesses expected 0", obs_bus.size());
            obs_bus.delete();
        end
    endtask

    task automatic test_read(input string name, input logic [23:0] a, input bit toggle,
                             input logic [31:0] a0, input logic [3:0] be0,
                             input logic [31:0] a1, input logic [3:0] be1,
                             input logic [31:0] bytes);
        bit ok; int n; bus_t e, o; logic [7:0] eb, ob;
        lat = 0;
        rd_ready = 1'b0;
        exp_bus.push_back(bus_t'{1'b0, a0, be0, 32'h0});
        exp_bus.push_back(bus_t'{1'b0, a1, be1, 32'h0});
        for (int i = 0; i < 4; i++) exp_rd.push_back(bytes[8*i +: 8]);
        start_cmd(1'b0, a, 16'd4);
        wait_done(200, toggle, ok, n);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++; $display("FAIL %s_done: got no done expected done", name);
        end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); vectors++;
            if (obs_bus.size() == 0) begin
                miscompares++; $display("FAIL %s_bus: got no access expected a=%h be=%b", name, e.a, e.be);
            end else begin
                o = obs_bus.pop_front();
                if ({o.wr, o.a, o.be} !== {e.wr, e.a, e.be}) begin
                    miscompares++;
                    $display("FAIL %s_bus: got wr=%b a=%h be=%b expected wr=%b a=%h be=%b",
                             name, o.wr, o.a, o.be, e.wr, e.a, e.be);
                end
            end
        end
        vectors++;
        if (obs_bus.size() != 0) begin
            miscompares++; $display("FAIL %s_extra: got %0d extra accesses expected 0", name, obs_bus.size());
            obs_bus.delete();
        end
        while (exp_rd.size() > 0) begin
            eb = exp_rd.pop_front(); vectors++;
            if (obs_rd.size() == 0) begin
                miscompares++; $display("FAIL %s_stream: got no byte expected %h", name, eb);
            end else begin
                ob = obs_rd.pop_front();
                if (ob !== eb) begin
                    miscompares++; $display("FAIL %s_stream: got %h expected %h", name, ob, eb);
                end
            end
        end
        vectors++;
        if (obs_rd.size() != 0) begin
            miscompares++; $display("FAIL %s_stream_extra: got %0d extra bytes expected 0", name, obs_rd.size());
            obs_rd.delete();
        end
    endtask

    task automatic test_zero_len();
        bit ok; int n, snap;
        snap = strobe_cnt;
        start_cmd(1'b0, 24'h123456, 16'd0);
        wait_done(10, 1'b0, ok, n);
        vectors++;
        if ({ok, n} !== {1'b1, 32'd0}) begin
            miscompares++; $display("FAIL zero_len_done: got ok=%b delay=%0d expected ok=1 delay=0", ok, n);
        end
        vectors++;
        if ({strobe_cnt - snap, busy} !== {32'd0, 1'b0}) begin
            miscompares++; $display("FAIL zero_len_strobe: got %0d strobe cycles busy=%b expected 0 busy=0", strobe_cnt - snap, busy);
        end
    endtask

    task automatic test_timeout();
        bit ok1, ok2; int n, snap;
        lat = 0; stuck = 1'b1;
        for (int i = 0; i < 4; i++) src[i] = 8'(8'h50 + i);
        snap = wr_hi;
        start_cmd(1'b1, 24'h000200, 16'd4);
        feed(4, ok1);
        wait_done(100, 1'b0, ok2, n);
        vectors++;
        if ({ok1, ok2} !== 2'b11) begin
            miscompares++; $display("FAIL timeout_done: got feed/done %b expected 11", {ok1, ok2});
        end
        vectors++;
        if (wr_hi - snap !== 8) begin
            miscompares++; $display("FAIL timeout_wr_cycles: got %0d expected 8", wr_hi - snap);
        end
        vectors++;
        if ({err, cmd_ready, busy, IO_WR} !== 4'b1100) begin
            miscompares++; $display("FAIL timeout_flags: got err/cmd_ready/busy/wr %b expected 1100", {err, cmd_ready, busy, IO_WR});
        end
        vectors++;
        if (obs_bus.size() != 0) begin
            miscompares++; $display("FAIL timeout_bus: got %0d completed accesses expected 0", obs_bus.size());
            obs_bus.delete();
        end
        stuck = 1'b0;
        start_cmd(1'b1, 24'h000300, 16'd0);
        wait_done(10, 1'b0, ok2, n);
        vectors++;
        if ({ok2, err} !== 2'b10) begin
            miscompares++; $display("FAIL timeout_err_clear: got done/err %b expected 10", {ok2, err});
        end
    endtask

    task automatic test_idle_ready();
        int snap_d, snap_s;
        snap_d = done_cnt; snap_s = strobe_cnt;
        idle_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if ({busy, cmd_ready, done_cnt - snap_d, strobe_cnt - snap_s} !== {2'b01, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL idle_ready: got busy=%b cmd_ready=%b dones=%0d strobes=%0d expected 0 1 0 0",
                     busy, cmd_ready, done_cnt - snap_d, strobe_cnt - snap_s);
        end
        idle_ready = 1'b0;
    endtask

    task automatic test_reset_mid_rbus();
        bit seen; int snap;
        stuck = 1'b1; seen = 1'b0;
        snap = done_cnt;
        start_cmd(1'b0, 24'h000040, 16'd4);
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (IO_RD) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (seen !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_rd_start: got IO_RD=0 expected IO_RD=1");
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({IO_RD, IO_WR, busy, cmd_ready, done, rd_valid, IO_BE} !== 10'b0001_00_0000) begin
            miscompares++;
            $display("FAIL rst_mid_rd: got rd/wr/busy/cmd_ready/done/rd_valid/be %b expected 0001000000",
                     {IO_RD, IO_WR, busy, cmd_ready, done, rd_valid, IO_BE});
        end
        @(posedge clk); #1;
        rst = 1'b0; stuck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (done_cnt - snap !== 0) begin
            miscompares++; $display("FAIL rst_mid_rd_done: got %0d done pulses expected 0", done_cnt - snap);
        end
        obs_bus.delete();
        obs_rd.delete();
    endtask

    task automatic test_strobe_rule();
        vectors++;
        if (overlap !== 0) begin
            miscompares++; $display("FAIL strobe_overlap: got %0d cycles with IO_RD&IO_WR expected 0", overlap);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0]  = 32'h4433_2211;
        mem[1]  = 32'h8877_6655;
        mem[15] = 32'hDDCC_BBAA;
        test_reset();
        test_write_aligned();
        test_write_unaligned();
        test_back_to_back();
        test_read("rd_bp", 24'h000002, 1'b1, 32'h0000_0000, 4'b1100, 32'h0000_0004, 4'b0011, 32'h6655_4433);
        test_read("rd_wrap", 24'hFFFFFE, 1'b0, 32'h00FF_FFFC, 4'b1100, 32'h0000_0000, 4'b0011, 32'h2211_DDCC);
        test_zero_len();
        test_timeout();
        test_idle_ready();
        test_reset_mid_rbus();
        test_strobe_rule();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
